// File: rtl/bcd_updown_counter.sv
// ============================================================================
// bcd_updown_counter
// ----------------------------------------------------------------------------
// Multi-digit packed-BCD up/down counter with synchronous load, optional
// wrap-around or saturation at the limits, and one-cycle overflow/underflow
// pulses.
//
// Parameters
//   DIGITS     : number of BCD digits (1..4)
//   WRAP       : 1 = wrap around at the limits, 0 = saturate at the limits
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   reset      : asynchronous, active-high; clears value, ovf and unf
//   inc_btn    : +1 request for this cycle
//   dec_btn    : -1 request for this cycle
//   load       : synchronous load of load_value (highest priority)
//   load_value : packed BCD value to load, digit 0 in bits [3:0]
//   value      : registered packed BCD count, digit 0 in bits [3:0]
//   at_max     : high while every digit of value is 9
//   at_min     : high while value is all zeros
//   ovf        : registered pulse, increment requested while at_max
//   unf        : registered pulse, decrement requested while at_min
// ============================================================================
module bcd_updown_counter #(
   parameter int DIGITS = 2,
   parameter int WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc_btn,
   input  logic                  dec_btn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   value,
   output logic                  at_max,
   output logic                  at_min,
   output logic                  ovf,
   output logic                  unf
);

   localparam int              W         = 4 * DIGITS;
   localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'h9}};

   logic [W-1:0] inc_value;
   logic [W-1:0] dec_value;
   logic [W-1:0] clamped_value;
   logic         carry;
   logic         borrow;

   // Limit flags come straight off the registered count so they track it
   // with no extra latency.
   assign at_max = (value == ALL_NINES);
   assign at_min = (value == '0);

   // Decimal +1: the carry ripples through every digit sitting at 9 within
   // the same cycle. Digits above the first non-9 digit are passed through.
   always_comb begin
      inc_value = '0;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!carry) begin
            inc_value[4*i +: 4] = value[4*i +: 4];
         end else if (value[4*i +: 4] >= 4'd9) begin
            inc_value[4*i +: 4] = 4'd0;
         end else begin
            inc_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
            carry               = 1'b0;
         end
      end
   end

   // Decimal -1: the borrow ripples through every digit sitting at 0,
   // turning each into 9, until a nonzero digit absorbs it.
   always_comb begin
      dec_value = '0;
      borrow    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!borrow) begin
            dec_value[4*i +: 4] = value[4*i +: 4];
         end else if (value[4*i +: 4] == 4'd0) begin
            dec_value[4*i +: 4] = 4'd9;
         end else begin
            dec_value[4*i +: 4] = value[4*i +: 4] - 4'd1;
            borrow              = 1'b0;
         end
      end
   end

   // Loaded nibbles above 9 are clamped to 9 so an illegal BCD code can
   // never reach the count register.
   always_comb begin
      clamped_value = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_value[4*i +: 4] > 4'd9) begin
            clamped_value[4*i +: 4] = 4'd9;
         end else begin
            clamped_value[4*i +: 4] = load_value[4*i +: 4];
         end
      end
   end

   // Count register and limit pulses. Load beats any count request; an
   // inc and dec arriving together cancel. At a limit the count either
   // wraps to the opposite limit or stays put, and the matching pulse
   // fires for that one cycle only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
         if (load) begin
            value <= clamped_value;
         end else if (inc_btn && !dec_btn) begin
            if (at_max) begin
               ovf   <= 1'b1;
               value <= (WRAP != 0) ? '0 : ALL_NINES;
            end else begin
               value <= inc_value;
            end
         end else if (dec_btn && !inc_btn) begin
            if (at_min) begin
               unf   <= 1'b1;
               value <= (WRAP != 0) ? ALL_NINES : '0;
            end else begin
               value <= dec_value;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
// tb_bcd_updown_counter
// ----------------------------------------------------------------------------
// Drives three counter instances from one shared stimulus stream:
//   dut 0 : DIGITS=2, WRAP=1
//   dut 1 : DIGITS=2, WRAP=0
//   dut 2 : DIGITS=4, WRAP=1
// An integer-valued model of each counter is compared against the
// hardware every falling edge; directed scenarios add literal checks.
// ============================================================================
module tb_bcd_updown_counter;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        inc_btn = 1'b0;
   logic        dec_btn = 1'b0;
   logic        load    = 1'b0;
   logic [7:0]  lv2     = 8'h00;
   logic [15:0] lv4     = 16'h0000;

   logic [7:0]  v0, v1;
   logic [15:0] v2;
   logic        mx0, mn0, ov0, un0;
   logic        mx1, mn1, ov1, un1;
   logic        mx2, mn2, ov2, un2;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Model state: the count held as a plain integer per instance.
   int cnt   [3] = '{0, 0, 0};
   bit m_ovf [3] = '{0, 0, 0};
   bit m_unf [3] = '{0, 0, 0};
   int maxv  [3] = '{99, 99, 9999};
   int ndig  [3] = '{2, 2, 4};
   bit wrap  [3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_w1 (
      .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .load(load), .load_value(lv2), .value(v0),
      .at_max(mx0), .at_min(mn0), .ovf(ov0), .unf(un0));

   bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_w0 (
      .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .load(load), .load_value(lv2), .value(v1),
      .at_max(mx1), .at_min(mn1), .ovf(ov1), .unf(un1));

   bcd_updown_counter #(.DIGITS(4), .WRAP(1)) u_d4 (
      .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .load(load), .load_value(lv4), .value(v2),
      .at_max(mx2), .at_min(mn2), .ovf(ov2), .unf(un2));

   // Decimal value of a packed BCD word, each nibble clamped to 9.
   function automatic int clampLoad(logic [15:0] lv, int nd);
      int r;
      int d;
      r = 0;
      for (int i = nd - 1; i >= 0; i--) begin
         d = int'(lv[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   // Packed BCD encoding of a decimal integer.
   function automatic logic [15:0] toBcd(int n, int nd);
      logic [15:0] r;
      int          x;
      r = '0;
      x = n;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference behaviour: integer counter from 0 to 10^DIGITS-1.
   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            cnt[k]   = 0;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
         end else begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            if (load) begin
               cnt[k] = clampLoad((k == 2) ? lv4 : {8'h00, lv2}, ndig[k]);
            end else if (inc_btn && !dec_btn) begin
               if (cnt[k] == maxv[k]) begin
                  m_ovf[k] = 1'b1;
                  cnt[k]   = wrap[k] ? 0 : maxv[k];
               end else begin
                  cnt[k] = cnt[k] + 1;
               end
            end else if (dec_btn && !inc_btn) begin
               if (cnt[k] == 0) begin
                  m_unf[k] = 1'b1;
                  cnt[k]   = wrap[k] ? maxv[k] : 0;
               end else begin
                  cnt[k] = cnt[k] - 1;
               end
            end
         end
      end
   end

   task automatic cmpDut(int k, logic [15:0] act, logic amax, logic amin,
                         logic aovf, logic aunf);
      logic [15:0] ev;
      logic        emax, emin;
      ev   = toBcd(cnt[k], ndig[k]);
      emax = (cnt[k] == maxv[k]);
      emin = (cnt[k] == 0);
      checks++;
      if (act !== ev || amax !== emax || amin !== emin ||
          aovf !== m_ovf[k] || aunf !== m_unf[k]) begin
         errors++;
         $display("[TB] FAIL model_cmp dut%0d t=%0t: got val=%h max=%b min=%b ovf=%b unf=%b, expected val=%h max=%b min=%b ovf=%b unf=%b",
                  k, $time, act, amax, amin, aovf, aunf,
                  ev, emax, emin, m_ovf[k], m_unf[k]);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (check_en) begin
         cmpDut(0, {8'h00, v0}, mx0, mn0, ov0, un0);
         cmpDut(1, {8'h00, v1}, mx1, mn1, ov1, un1);
         cmpDut(2, v2, mx2, mn2, ov2, un2);
      end
   end

   task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of requests, then return just after the rising edge
   // that consumed them; inputs stay put until the next call.
   task automatic applyStimulus(bit i, bit d, bit l, logic [7:0] a, logic [15:0] b);
      inc_btn = i;
      dec_btn = d;
      load    = l;
      lv2     = a;
      lv4     = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          ri, rd, rl;
      logic [7:0]  ra;
      logic [15:0] rb;

      $display("[TB] start");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_v0", {8'h00, v0}, 16'h0000);
      checkOutput("reset_v2", v2, 16'h0000);
      checkOutput("reset_min", {15'd0, mn0}, 16'd1);
      reset    = 1'b0;
      check_en = 1'b1;

      // Ten increments from zero carry into the tens digit.
      for (int n = 0; n < 10; n++) applyStimulus(1, 0, 0, 8'h00, 16'h0000);
      checkOutput("ten_incs", {8'h00, v0}, 16'h0010);
      checkOutput("ten_incs_flags", {12'd0, mx0, mn0, ov0, un0}, 16'h0000);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);

      // Wrap at the top and bottom, plus a three-digit carry ripple.
      applyStimulus(0, 0, 1, 8'h99, 16'h0999);
      checkOutput("load_99", {8'h00, v0}, 16'h0099);
      applyStimulus(1, 0, 0, 8'h00, 16'h0000);
      checkOutput("wrap_inc", {8'h00, v0}, 16'h0000);
      checkOutput("wrap_ovf", {15'd0, ov0}, 16'd1);
      checkOutput("d4_ripple", v2, 16'h1000);
      applyStimulus(0, 1, 0, 8'h00, 16'h0000);
      checkOutput("wrap_dec", {8'h00, v0}, 16'h0099);
      checkOutput("wrap_unf", {14'd0, ov0, un0}, 16'd1);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);

      // Saturation: three increments at 99 each pulse ovf.
      applyStimulus(0, 0, 1, 8'h99, 16'h9999);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 0, 0, 8'h00, 16'h0000);
         checkOutput("sat_inc", {7'd0, ov1, v1}, 16'h0199);
      end
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);
      checkOutput("sat_ovf_drop", {15'd0, ov1}, 16'd0);
      applyStimulus(0, 0, 1, 8'h00, 16'h0000);
      applyStimulus(0, 1, 0, 8'h00, 16'h0000);
      checkOutput("sat_dec", {7'd0, un1, v1}, 16'h0100);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);

      // Simultaneous inc+dec cancels; load beats inc and clamps 0xC to 9.
      applyStimulus(0, 0, 1, 8'h40, 16'h0000);
      applyStimulus(1, 1, 0, 8'h00, 16'h0000);
      checkOutput("inc_dec_hold", {6'd0, ov0, un0, v0}, 16'h0040);
      applyStimulus(1, 0, 1, 8'h3C, 16'hFA3C);
      checkOutput("load_clamp", {7'd0, ov0, v0}, 16'h0039);
      checkOutput("load_clamp_d4", v2, 16'h9939);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);

      // Borrow from the tens digit.
      applyStimulus(0, 0, 1, 8'h10, 16'h0000);
      applyStimulus(0, 1, 0, 8'h00, 16'h0000);
      checkOutput("borrow", {8'h00, v0}, 16'h0009);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);

      // Reset between edges clears the count before the next edge.
      applyStimulus(0, 0, 1, 8'h57, 16'h0057);
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);
      checkOutput("pre_reset", {8'h00, v0}, 16'h0057);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_reset", {6'd0, ov0, un0, v0}, 16'h0000);
      checkOutput("async_reset_d4", v2, 16'h0000);
      #1 reset = 1'b0;

      // Randomized traffic, including illegal load nibbles.
      for (int n = 0; n < 3000; n++) begin
         rl = ($urandom_range(15) == 0);
         ri = ($urandom_range(99) < 45);
         rd = ($urandom_range(99) < 45);
         ra = 8'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(3) == 0) begin
            ra = 8'h99;
            rb = 16'h9999;
         end
         applyStimulus(ri, rd, rl, ra, rb);
      end
      applyStimulus(0, 0, 0, 8'h00, 16'h0000);
      @(negedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
